// File: rtl/cpu_run_controller_if.sv
// Dump-port bundle: the controller borrows the data-memory read port and streams words out.
interface cpu_run_controller_if #(
  parameter int DUMP_WORDS = 64
);
  localparam int IDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;

  logic             dump_req;
  logic             dump_sel;
  logic [31:0]      dump_a;
  logic [31:0]      dump_rd;
  logic             dump_valid;
  logic             dump_ready;
  logic [31:0]      dump_data;
  logic [IDX_W-1:0] dump_index;
  logic             dump_done;

  modport master (
    input  dump_req, dump_rd, dump_ready,
    output dump_sel, dump_a, dump_valid, dump_data, dump_index, dump_done
  );

  modport slave (
    output dump_req, dump_rd, dump_ready,
    input  dump_sel, dump_a, dump_valid, dump_data, dump_index, dump_done
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Run/halt sequencer for the single-cycle MIPS core: gates every architectural commit
// and dumps the low data-memory words while halted.
module cpu_run_controller #(
  parameter int DUMP_WORDS = 64,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic              halt_req,
  input  logic [CNT_W-1:0]  cycle_limit,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  output logic              commit_en,
  output logic              halted,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_count,
  cpu_run_controller_if.master dump
);
  localparam int IDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP      = 3'd2,
    ST_HALTED    = 3'd3,
    ST_DUMP_ADDR = 3'd4,
    ST_DUMP_OUT  = 3'd5
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] count_r, count_inc_s;
  logic [IDX_W-1:0] idx_r, dump_index_r;
  logic [31:0]      dump_data_r;
  logic             dump_valid_r, dump_done_r, skip_bp_r, halted_r, busy_r;
  logic             bp_hit_s, limit_hit_s, handshake_s, last_word_s;
  logic             commit_en_s, dump_sel_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: halt_req beats breakpoint beats cycle budget in RUN
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else if (step) begin
          state_nxt_s = ST_STEP;
        end else if (dump.dump_req) begin
          state_nxt_s = ST_DUMP_ADDR;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (halt_req || bp_hit_s || limit_hit_s) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STEP:      state_nxt_s = ST_HALTED;
      ST_DUMP_ADDR: state_nxt_s = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (handshake_s) begin
          state_nxt_s = last_word_s ? ST_HALTED : ST_DUMP_ADDR;
        end else begin
          state_nxt_s = ST_DUMP_OUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Combinational outputs and per-cycle qualifiers
  always_comb begin
    bp_hit_s    = bp_en & (pc == bp_addr) & ~skip_bp_r;
    count_inc_s = count_r + CNT_ONE;
    limit_hit_s = (cycle_limit != {CNT_W{1'b0}}) & (count_inc_s == cycle_limit);
    handshake_s = dump_valid_r & dump.dump_ready;
    last_word_s = (idx_r == LAST_IDX);
    commit_en_s = 1'b0;
    dump_sel_s  = 1'b0;
    case (state_r)
      ST_RUN:                    commit_en_s = ~halt_req & ~bp_hit_s;
      ST_STEP:                   commit_en_s = 1'b1;
      ST_DUMP_ADDR, ST_DUMP_OUT: dump_sel_s  = 1'b1;
      default: begin
        commit_en_s = 1'b0;
        dump_sel_s  = 1'b0;
      end
    endcase
  end

  // Instruction counter, breakpoint skip, dump capture and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r      <= {CNT_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      dump_index_r <= {IDX_W{1'b0}};
      dump_data_r  <= 32'd0;
      dump_valid_r <= 1'b0;
      dump_done_r  <= 1'b0;
      skip_bp_r    <= 1'b0;
      halted_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      dump_done_r <= 1'b0;
      halted_r    <= (state_nxt_s == ST_HALTED);
      busy_r      <= (state_nxt_s == ST_RUN) | (state_nxt_s == ST_STEP) |
                     (state_nxt_s == ST_DUMP_ADDR) | (state_nxt_s == ST_DUMP_OUT);
      case (state_r)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            // Resuming from HALTED must not re-trip on the breakpoint we stopped at
            if (state_r == ST_IDLE) count_r <= {CNT_W{1'b0}};
            skip_bp_r <= (state_r == ST_HALTED);
          end else if (step) begin
            if (state_r == ST_IDLE) count_r <= {CNT_W{1'b0}};
          end else if (dump.dump_req) begin
            idx_r <= {IDX_W{1'b0}};
          end
        end
        ST_RUN: begin
          skip_bp_r <= 1'b0;
          if (commit_en_s) count_r <= count_inc_s;
        end
        ST_STEP: count_r <= count_inc_s;
        ST_DUMP_ADDR: begin
          dump_data_r  <= dump.dump_rd;
          dump_index_r <= idx_r;
          dump_valid_r <= 1'b1;
        end
        ST_DUMP_OUT: begin
          if (handshake_s) begin
            dump_valid_r <= 1'b0;
            if (last_word_s) begin
              dump_done_r <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end
        end
        default: dump_valid_r <= 1'b0;
      endcase
    end
  end

  assign commit_en       = commit_en_s;
  assign halted          = halted_r;
  assign busy            = busy_r;
  assign cycle_count     = count_r;
  assign dump.dump_sel   = dump_sel_s;
  assign dump.dump_a     = {{(30-IDX_W){1'b0}}, idx_r, 2'b00};
  assign dump.dump_valid = dump_valid_r;
  assign dump.dump_data  = dump_data_r;
  assign dump.dump_index = dump_index_r;
  assign dump.dump_done  = dump_done_r;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized and directed bench for cpu_run_controller against a mode-level reference model.
module tb_cpu_run_controller;
  localparam int DW = 64;

  logic        clk, rst_n;
  logic        start, step, halt_req, bp_en;
  logic [31:0] cycle_limit, bp_addr, pc;
  logic        commit_en, halted, busy;
  logic [31:0] cycle_count;
  logic [31:0] mem [DW];

  cpu_run_controller_if #(.DUMP_WORDS(DW)) dif ();

  cpu_run_controller #(.DUMP_WORDS(DW), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .halt_req(halt_req),
    .cycle_limit(cycle_limit), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .commit_en(commit_en), .halted(halted), .busy(busy), .cycle_count(cycle_count),
    .dump(dif)
  );

  assign dif.dump_rd = mem[dif.dump_a[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_commit = 0;
  int n_acc    = 0;
  int n_done   = 0;
  bit lit_dump = 1'b0;
  bit commit_obs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference model: coarse modes; a dump is one mode with a "word presented" flag
  typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT, M_DUMP} mode_t;
  mode_t       m_mode;
  logic [31:0] m_count, m_data;
  bit          m_skip, m_present, m_done;
  int          m_word, m_index;

  function automatic bit m_commit();
    if (m_mode == M_STEP) return 1'b1;
    if (m_mode == M_RUN) return !halt_req && !(bp_en && pc == bp_addr && !m_skip);
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_count = 32'd0; m_data = 32'd0; m_skip = 1'b0;
    m_present = 1'b0; m_done = 1'b0; m_word = 0; m_index = 0;
  endtask

  task automatic model_step();
    bit c;
    c = m_commit();
    m_done = 1'b0;
    case (m_mode)
      M_IDLE, M_HALT: begin
        if (start) begin
          if (m_mode == M_IDLE) m_count = 32'd0;
          m_skip = (m_mode == M_HALT);
          m_mode = M_RUN;
        end else if (step) begin
          if (m_mode == M_IDLE) m_count = 32'd0;
          m_mode = M_STEP;
        end else if (dif.dump_req) begin
          m_mode = M_DUMP; m_word = 0; m_present = 1'b0;
        end
      end
      M_RUN: begin
        m_skip = 1'b0;
        if (!c) m_mode = M_HALT;
        else begin
          m_count = m_count + 32'd1;
          if (cycle_limit != 32'd0 && m_count == cycle_limit) m_mode = M_HALT;
        end
      end
      M_STEP: begin
        m_count = m_count + 32'd1;
        m_mode = M_HALT;
      end
      M_DUMP: begin
        if (!m_present) begin
          m_present = 1'b1; m_data = mem[m_word]; m_index = m_word;
        end else if (dif.dump_ready) begin
          m_present = 1'b0;
          if (m_word == DW - 1) begin
            m_mode = M_HALT; m_done = 1'b1;
          end else m_word++;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every negedge out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk_b("commit_en", commit_en, m_commit());
        chk_b("halted", halted, m_mode == M_HALT);
        chk_b("busy", busy, m_mode inside {M_RUN, M_STEP, M_DUMP});
        chk("cycle_count", cycle_count, m_count);
        chk_b("dump_sel", dif.dump_sel, m_mode == M_DUMP);
        if (m_mode == M_DUMP) chk("dump_a", dif.dump_a, 32'(m_word * 4));
        chk_b("dump_valid", dif.dump_valid, m_present);
        chk("dump_data", dif.dump_data, m_data);
        chk("dump_index", {26'd0, dif.dump_index}, 32'(m_index));
        chk_b("dump_done", dif.dump_done, m_done);
        if (commit_en) n_commit++;
        if (lit_dump && dif.dump_valid && dif.dump_ready) begin
          chk("seq_index", {26'd0, dif.dump_index}, 32'(n_acc));
          chk("seq_data", dif.dump_data, 32'(n_acc * 3));
          n_acc++;
        end
        if (lit_dump && dif.dump_done) n_done++;
        commit_obs = commit_en;
      end else begin
        commit_obs = 1'b0;
      end
    end
  end

  // The core's PC flop: advances by 4 on every observed commit
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'd0;
    else if (commit_obs) pc <= pc + 32'd4;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_b({tag, "_commit"}, commit_en, 1'b0);
    chk_b({tag, "_valid"}, dif.dump_valid, 1'b0);
    chk_b({tag, "_sel"}, dif.dump_sel, 1'b0);
    chk_b({tag, "_halted"}, halted, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_count"}, cycle_count, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0; bp_en = 1'b0;
    cycle_limit = 32'd0; bp_addr = 32'd0;
    dif.dump_req = 1'b0; dif.dump_ready = 1'b0;
    for (int i = 0; i < DW; i++) mem[i] = 32'(i * 3);
    #1;
    pulse_reset();
    check_reset_outputs("reset");
    chk_b("reset_done", dif.dump_done, 1'b0);

    // Cycle budget of 323 committed instructions
    cycle_limit = 32'd323; n_commit = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 400 && !halted; k++) tick();
    chk("limit_commits", 32'(n_commit), 32'd323);
    chk("limit_count", cycle_count, 32'd323);
    chk_b("limit_halted", halted, 1'b1);

    // Breakpoint at 0x10, then resume past it
    pulse_reset();
    cycle_limit = 32'd0; bp_en = 1'b1; bp_addr = 32'h10;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 50 && !halted; k++) tick();
    chk("bp_pc", pc, 32'h10);
    chk("bp_count", cycle_count, 32'd4);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("resume_count", cycle_count, 32'd5);
    chk("resume_pc", pc, 32'h14);
    chk_b("resume_halted", halted, 1'b1);

    // Three single steps; halt_req in a STEP cycle is ignored
    n_commit = 0;
    for (int s = 0; s < 3; s++) begin
      step = 1'b1; tick(); step = 1'b0;
      halt_req = (s == 1); tick(); halt_req = 1'b0;
      chk_b("step_halted", halted, 1'b1);
    end
    chk("step_commits", 32'(n_commit), 32'd3);
    chk("step_count", cycle_count, 32'd8);

    // halt_req and breakpoint on the cycle the budget would be met
    bp_en = 1'b0; cycle_limit = 32'd10;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    halt_req = 1'b1; bp_en = 1'b1; bp_addr = pc; tick();
    halt_req = 1'b0; bp_en = 1'b0;
    chk("prio_count", cycle_count, 32'd9);
    chk_b("prio_halted", halted, 1'b1);

    // Full dump with ready toggling
    n_acc = 0; n_done = 0; lit_dump = 1'b1;
    dif.dump_req = 1'b1; tick(); dif.dump_req = 1'b0;
    for (int k = 0; k < 400 && !halted; k++) begin
      dif.dump_ready = ~dif.dump_ready;
      tick();
    end
    tick();
    lit_dump = 1'b0;
    chk("dump_words", 32'(n_acc), 32'd64);
    chk("dump_done_cnt", 32'(n_done), 32'd1);
    chk("dump_last_data", dif.dump_data, 32'd189);

    // Reset in the middle of a dump
    dif.dump_ready = 1'b1; dif.dump_req = 1'b1; tick(); dif.dump_req = 1'b0;
    for (int k = 0; k < 200 && !(dif.dump_valid && dif.dump_index == 6'd20); k++) tick();
    chk("mid_dump_index", {26'd0, dif.dump_index}, 32'd20);
    #2;
    chk_b("mid_dump_sel_before", dif.dump_sel, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_dump");
    @(posedge clk); #1; rst_n = 1'b1;
    tick(); tick();
    chk_b("rst_dump_no_done", dif.dump_done, 1'b0);

    // Reset in the middle of a run
    cycle_limit = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    #2;
    chk_b("mid_run_commit_before", commit_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_run");
    @(posedge clk); #1; rst_n = 1'b1;

    // Randomized phase
    for (int i = 0; i < DW; i++) mem[i] = $urandom;
    for (int k = 0; k < 4000; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      start = (r < 4);
      step = (r >= 4 && r < 9);
      dif.dump_req = ($urandom_range(0, 9) == 0);
      halt_req = ($urandom_range(0, 19) == 0);
      dif.dump_ready = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 31) == 0) begin
        bp_en = $urandom_range(0, 1) != 0;
        bp_addr = pc + 32'($urandom_range(0, 10) * 4);
        cycle_limit = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Run/halt sequencer for the single-cycle MIPS core. Gates every architectural commit (PC update, register write, data-memory write) through one enable, so the core can be started, single-stepped, stopped on a cycle budget or PC breakpoint, and externally halted. While halted it borrows the data-memory read port and streams the first DUMP_WORDS words out over a valid/ready interface. This replaces fixed-cycle bench loops and hierarchical memory peeks.

Parameters:
DUMP_WORDS, 64, number of 32-bit words dumped, addresses 0..4*(DUMP_WORDS-1)
CNT_W, 32, width of cycle counter and cycle_limit

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin/resume free run (level sampled per cycle)
step  in  1  execute exactly one instruction
halt_req  in  1  stop before committing the current instruction
cycle_limit  in  CNT_W  committed-instruction budget; 0 = unlimited
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
pc  in  32  current PC from program-counter flop
commit_en  out  1  integrator ANDs into PC load, register_we3, data_memory_we
halted  out  1  high in HALTED
busy  out  1  high in RUN, STEP, DUMP_ADDR, DUMP_OUT
cycle_count  out  CNT_W  committed instructions since last start from IDLE
dump_req  in  1  request memory dump (honoured in IDLE/HALTED only)
dump_sel  out  1  when high, data_memory_a is muxed to dump_a
dump_a  out  32  dump read address
dump_rd  in  32  data_memory_rd (combinational read)
dump_valid  out  1  dump_data valid
dump_ready  in  1  consumer accepts word
dump_data  out  32  registered word
dump_index  out  clog2(DUMP_WORDS)  word index of dump_data
dump_done  out  1  one-cycle pulse on last accepted word

Behaviour:
- States: IDLE, RUN, STEP, HALTED, DUMP_ADDR, DUMP_OUT.
- Reset (async, immediate): state=IDLE. cycle_count, dump_index, dump_data = 0. dump_valid, dump_done, halted, busy = 0. skip_bp = 0.
- commit_en is combinational from state and inputs, so it drops to 0 as soon as rst_n falls.
- Priority in IDLE/HALTED: start > step > dump_req.
- IDLE:
  - start -> RUN; cycle_count cleared to 0.
  - step -> STEP; cycle_count cleared.
  - dump_req -> DUMP_ADDR with idx=0.
- HALTED:
  - start -> RUN; count kept; skip_bp=1.
  - step -> STEP; count kept.
  - dump_req -> DUMP_ADDR with idx=0.
- RUN, each cycle:
  - bp_hit = bp_en & (pc==bp_addr) & !skip_bp.
  - commit_en = !halt_req & !bp_hit.
  - If halt_req or bp_hit: -> HALTED, no commit.
  - Otherwise commit: cycle_count+1. If cycle_limit!=0 and cycle_count+1==cycle_limit -> HALTED after this commit.
  - skip_bp clears after the first RUN cycle.
  - Priority: halt_req > bp_hit > limit.
- STEP: commit_en=1 for exactly one cycle, cycle_count+1, -> HALTED. halt_req and breakpoint are ignored in STEP.
- commit_en=0 in every state except the qualifying RUN/STEP cycles.
- cycle_count wraps modulo 2^CNT_W; no saturation.
- DUMP_ADDR:
  - dump_sel=1, dump_a = idx*4.
  - Capture dump_rd into dump_data; dump_index=idx; dump_valid<=1; -> DUMP_OUT.
- DUMP_OUT:
  - dump_sel=1; hold dump_data and dump_index stable while !dump_ready.
  - On dump_valid & dump_ready: dump_valid<=0.
  - If idx==DUMP_WORDS-1: dump_done pulse next cycle, -> HALTED.
  - Else idx+1 -> DUMP_ADDR.
  - Throughput: 1 word per 2 cycles with ready held high.
- start, step and halt_req are ignored during a dump; a dump always completes and returns to HALTED, even when started from IDLE.
- Reset mid-dump or mid-run aborts at once: dump_valid=0, dump_sel=0, no dump_done.
- halted = (state==HALTED); busy = RUN|STEP|DUMP_*.

Test Plan:
- Reset, start=1 for 1 cycle, cycle_limit=323 -> commit_en high exactly 323 cycles, then halted=1, cycle_count=323.
- cycle_limit=0, bp_en=1, bp_addr=0x10, PC increments by 4 from 0 -> commits at PC 0,4,8,0xC; HALTED with pc=0x10, cycle_count=4. Then start -> PC 0x10 commits (skip_bp), run continues.
- From HALTED, step three times -> exactly 3 single-cycle commit_en pulses, cycle_count +3, halted after each.
- In RUN, assert halt_req and bp_hit in the same cycle as the limit would be reached -> no commit that cycle, HALTED, cycle_count unchanged.
- Memory preloaded ram[i]=i*3, dump_req with ready toggling 1/0 -> 64 words, index 0..63, data 0..189, dump_done once on word 63, data stable while ready=0.
- Deassert rst_n mid-dump (index 20) and mid-run -> commit_en, dump_valid and dump_sel fall immediately; state IDLE; cycle_count=0.
